// File: rtl/irq_controller.sv
// irq_controller
// ---------------------------------------------------------------------------
// This is a programmable interrupt controller for a 68000 CPU. It sits
// between seven active-high peripheral interrupt sources and the CPU's
// IPL/IACK bus interface.
//
// - Interrupt sources are synchronised, then latched as level or edge.
// - A mask is applied. The highest active level drives the active-low IPL
//   pins.
// - Interrupt-acknowledge cycles are answered with a vector byte and
//   terminated with DTACK.
//
// Optional build macro: IRQ_CTRL_AUTOVEC_EN
//   When defined, this adds the vpa_n output and a 7-bit autovector enable
//   register.
//   - Writing register 3 with bit 7 set loads this enable register instead
//     of vbase.
//   - An acknowledged level with its autovector bit set is answered with
//     VPA instead of DTACK.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   irq_in[6:0]  interrupt sources, bit n-1 = level n (asynchronous)
//   cpu_as_n     CPU address strobe (asynchronous)
//   cpu_fc       CPU function code
//   cpu_addr_hi  CPU A19..A16
//   cpu_addr_lo  CPU A3..A1 (acknowledged level)
//   reg_cs       register select strobe (one cycle)
//   reg_we       1 = write, 0 = read
//   reg_addr     register index:
//                  0 mask, 1 pending (W1C), 2 edge_mode, 3 vbase
//   reg_wdata    register write data
//   reg_rdata    registered read data
//   ipl2_n..ipl0_n  encoded priority level, active low
//   vec_data     vector byte for D7..D0
//   vec_oe       drive enable for vec_data
//   dtack_n      cycle termination, active low
//   vpa_n        autovector request, active low (IRQ_CTRL_AUTOVEC_EN only)
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter logic [7:0]  VECTOR_BASE = 8'h40,
  parameter int unsigned IACK_WAIT   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] irq_in,
  input  logic       cpu_as_n,
  input  logic [2:0] cpu_fc,
  input  logic [3:0] cpu_addr_hi,
  input  logic [2:0] cpu_addr_lo,
  input  logic       reg_cs,
  input  logic       reg_we,
  input  logic [1:0] reg_addr,
  input  logic [7:0] reg_wdata,
  output logic [7:0] reg_rdata,
  output logic       ipl0_n,
  output logic       ipl1_n,
  output logic       ipl2_n,
  output logic [7:0] vec_data,
  output logic       vec_oe,
`ifdef IRQ_CTRL_AUTOVEC_EN
  output logic       dtack_n,
  output logic       vpa_n
`else
  output logic       dtack_n
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

  // Synchronisers. irq has a third stage for edge detection. The as_n
  // synchroniser idles high.
  logic [6:0] irq_s1_q, irq_s2_q, irq_s3_q;
  logic       as_s1_q, as_s2_q;

  logic [6:0] mask_q, edge_mode_q, pend_q, pend_d;
  logic [7:0] vbase_q, rdata_q;
  logic [2:0] ipl_q;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [2:0] lvl_q;
  logic [7:0] vec_q;
  logic       vec_oe_q, dtack_n_q;

  logic [6:0] rise, pending, active, w1c, iack_clr;
  logic [7:0] act8, ack_vec;
  logic [2:0] top_lvl, ack_lvl;
  logic       wr_en, rd_en, iack_det, ack_enter, ack_valid;

`ifdef IRQ_CTRL_AUTOVEC_EN
  logic [6:0] autovec_q;
  logic [7:0] av8;
  logic       vpa_n_q, ack_auto;
`endif

  // -------------------------------------------------------------------------
  // Input synchronisation
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
      irq_s3_q <= '0;
      as_s1_q  <= 1'b1;
      as_s2_q  <= 1'b1;
    end else begin
      irq_s1_q <= irq_in;
      irq_s2_q <= irq_s1_q;
      irq_s3_q <= irq_s2_q;
      as_s1_q  <= cpu_as_n;
      as_s2_q  <= as_s1_q;
    end
  end

  assign rise  = irq_s2_q & ~irq_s3_q;
  assign wr_en = reg_cs & reg_we;
  assign rd_en = reg_cs & ~reg_we;
  assign w1c   = (wr_en && reg_addr == 2'd1) ? reg_wdata[6:0] : 7'd0;

  // -------------------------------------------------------------------------
  // Per-level pending logic.
  // In level mode, pending follows the synchronised input directly. This
  // saves one cycle of latency compared with edge mode.
  // In edge mode, the latch bit is set by a rising edge. It is cleared by
  // W1C or by an acknowledge. A set beats a clear in the same cycle.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 7; gi++) begin : g_level
      assign pending[gi]  = edge_mode_q[gi] ? pend_q[gi] : irq_s2_q[gi];
      assign iack_clr[gi] = ack_enter & ack_valid & (ack_lvl == 3'(gi + 1));
      assign pend_d[gi]   = edge_mode_q[gi] &
                            (rise[gi] | (pend_q[gi] & ~(w1c[gi] | iack_clr[gi])));
    end
  endgenerate

  assign active = pending & mask_q;
  assign act8   = {active, 1'b0};   // index by level number; level 0 never active

  always_comb begin
    top_lvl = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (act8[i]) top_lvl = 3'(i);
    end
  end

  // -------------------------------------------------------------------------
  // Configuration registers, pending latch, IPL and read data
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q      <= '0;
      edge_mode_q <= '0;
      pend_q      <= '0;
      vbase_q     <= VECTOR_BASE;
      rdata_q     <= '0;
      ipl_q       <= 3'b111;
`ifdef IRQ_CTRL_AUTOVEC_EN
      autovec_q   <= '0;
`endif
    end else begin
      pend_q <= pend_d;
      ipl_q  <= ~top_lvl;
      if (wr_en) begin
        case (reg_addr)
          2'd0: mask_q      <= reg_wdata[6:0];
          2'd2: edge_mode_q <= reg_wdata[6:0];
          2'd3: begin
`ifdef IRQ_CTRL_AUTOVEC_EN
            if (reg_wdata[7]) autovec_q <= reg_wdata[6:0];
            else              vbase_q   <= reg_wdata;
`else
            vbase_q <= reg_wdata;
`endif
          end
          default: ;   // pending W1C is handled in the per-level logic
        endcase
      end
      if (rd_en) begin
        case (reg_addr)
          2'd0:    rdata_q <= {1'b0, mask_q};
          2'd1:    rdata_q <= {1'b0, pending};
          2'd2:    rdata_q <= {1'b0, edge_mode_q};
          default: rdata_q <= vbase_q;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // IACK handshake
  // -------------------------------------------------------------------------
  assign iack_det = ~as_s2_q & (cpu_fc == 3'b111) & (cpu_addr_hi == 4'hF);

  // ack_enter marks the edge on which ACK is entered. A zero wait skips
  // WAIT, so the level comes straight from the bus.
  always_comb begin
    ack_enter = 1'b0;
    ack_lvl   = lvl_q;
    case (state_q)
      S_IDLE: begin
        if (iack_det && IACK_WAIT == 0) begin
          ack_enter = 1'b1;
          ack_lvl   = cpu_addr_lo;
        end
      end
      S_WAIT:  ack_enter = ~as_s2_q & (cnt_q == 4'd0);
      default: ;
    endcase
  end

  assign ack_valid = act8[ack_lvl];
  assign ack_vec   = ack_valid ? (vbase_q + {5'd0, ack_lvl}) : 8'h18;

`ifdef IRQ_CTRL_AUTOVEC_EN
  assign av8      = {autovec_q, 1'b0};
  assign ack_auto = ack_valid & av8[ack_lvl];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      lvl_q     <= '0;
      vec_q     <= '0;
      vec_oe_q  <= 1'b0;
      dtack_n_q <= 1'b1;
`ifdef IRQ_CTRL_AUTOVEC_EN
      vpa_n_q   <= 1'b1;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iack_det) begin
            lvl_q   <= cpu_addr_lo;
            state_q <= S_WAIT;
            // Counting down to zero gives IACK_WAIT cycles from detection.
            cnt_q   <= 4'(IACK_WAIT - 1);
          end
        end
        S_WAIT: begin
          if (as_s2_q)              state_q <= S_IDLE;   // cycle aborted
          else if (cnt_q != 4'd0)   cnt_q   <= cnt_q - 4'd1;
        end
        S_ACK: begin
          if (as_s2_q) begin
            state_q   <= S_IDLE;
            vec_oe_q  <= 1'b0;
            dtack_n_q <= 1'b1;
`ifdef IRQ_CTRL_AUTOVEC_EN
            vpa_n_q   <= 1'b1;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (ack_enter) begin
        state_q <= S_ACK;
        vec_q   <= ack_vec;
`ifdef IRQ_CTRL_AUTOVEC_EN
        if (ack_auto) begin
          vpa_n_q <= 1'b0;
        end else begin
          vec_oe_q  <= 1'b1;
          dtack_n_q <= 1'b0;
        end
`else
        vec_oe_q  <= 1'b1;
        dtack_n_q <= 1'b0;
`endif
      end
    end
  end

  assign reg_rdata = rdata_q;
  assign ipl2_n    = ipl_q[2];
  assign ipl1_n    = ipl_q[1];
  assign ipl0_n    = ipl_q[0];
  assign vec_data  = vec_q;
  assign vec_oe    = vec_oe_q;
  assign dtack_n   = dtack_n_q;
`ifdef IRQ_CTRL_AUTOVEC_EN
  assign vpa_n     = vpa_n_q;
`endif

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Programmable interrupt controller between seven active-high peripheral interrupt sources and the 68000 IPL/IACK bus interface.
- Synchronises sources, latches them as level or edge, applies a mask, and drives the active-low IPL pins with the highest active level.
- Runs the interrupt-acknowledge bus cycle: returns a vector byte and terminates the cycle with DTACK.
- Configured through a small four-register interface from the system address decoder.

Parameters:
- VECTOR_BASE, 8'h40, reset value of the vector base register.
- IACK_WAIT, 2, clock cycles from IACK detection to vector/DTACK assertion (0..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- irq_in  in  7  interrupt sources, bit n-1 = level n, active high, asynchronous
- cpu_as_n  in  1  CPU address strobe, asynchronous
- cpu_fc  in  3  CPU function code
- cpu_addr_hi  in  4  CPU A19..A16
- cpu_addr_lo  in  3  CPU A3..A1 (acknowledged level)
- reg_cs  in  1  register select, one-cycle strobe
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  2  register index
- reg_wdata  in  8  write data
- reg_rdata  out  8  read data
- ipl0_n, ipl1_n, ipl2_n  out  1 each  encoded priority level, active low
- vec_data  out  8  vector byte for D7..D0
- vec_oe  out  1  data bus drive enable for vec_data
- dtack_n  out  1  cycle termination, active low

Behaviour:
- Clock and reset: single clock clk; rst_n asynchronous and active low.
- Reset values:
  - ipl*_n=1, dtack_n=1, vec_oe=0, vec_data=0, reg_rdata=0.
  - mask=0, pending=0, edge_mode=0, vbase=VECTOR_BASE.
  - FSM in IDLE; all synchroniser flops=0 (as_n synchroniser=1).
- Synchronisation: irq_in and cpu_as_n pass through two flops each. Edge detection compares sync stage 2 with a third delayed flop.
- Pending bit n:
  - Level mode (edge_mode[n]=0): pending[n] = synced irq level; W1C has no effect.
  - Edge mode: set on synced rising edge; cleared by W1C to reg 1 or by IACK of level n.
  - Set beats clear in the same cycle.
- Active and IPL:
  - active = pending & mask.
  - IPL registered: highest set bit of active, encoded active low (level 7 → 000, none → 111).
  - Latency irq_in rise → IPL change = 3 clk in level mode, 4 clk in edge mode.
- Registers (bits 6..0 = levels 7..1, bit 7 reads 0):
  - 0 mask, R/W.
  - 1 pending, R, W1C.
  - 2 edge_mode, R/W.
  - 3 vbase, R/W, all 8 bits.
- Register timing:
  - Writes take effect the clock after reg_cs&reg_we.
  - reg_rdata is registered, valid 1 clk after reg_cs&!reg_we; it holds its value otherwise.
- IACK detect: synced as_n low, cpu_fc=3'b111, cpu_addr_hi=4'hF. L = cpu_addr_lo, sampled on entry to WAIT.
- FSM:
  - IDLE → WAIT on IACK detect; load counter with IACK_WAIT.
  - WAIT: decrement the counter. At 0, go to ACK, registering vec_data, vec_oe=1, dtack_n=0.
  - ACK: hold outputs until synced as_n=1, then go to IDLE with vec_oe=0, dtack_n=1 on the same edge.
  - If as_n deasserts during WAIT, go to IDLE with no output and no pending clear.
- Vector:
  - If active[L] (and L≠0): vec_data = vbase+L (8-bit wrap) and, if edge mode, pending[L] is cleared on ACK entry.
  - Otherwise spurious: vec_data=8'h18, no state change.
- Non-IACK bus cycles are ignored. Register access during IACK is serviced normally.
- rst_n assertion mid-cycle returns to reset values immediately.

Optional Feature:
- Macro IRQ_CTRL_AUTOVEC_EN.
- Defined:
  - Adds output vpa_n (1 bit, reset 1) and register 3 bit mapping is unchanged; adds register slot: reg_addr 3 write with reg_wdata[7]=1 loads autovec[6:0] instead of vbase.
  - In ACK, a level with autovec[L]=1 asserts vpa_n=0 instead of dtack_n, with vec_oe=0. Release timing is the same as dtack_n.
  - Spurious acknowledges use vectored response.
- Not defined: no vpa_n port; all acknowledges vectored; reg 3 writes always load vbase.

Test Plan:
- Reset, mask=7F, level-mode irq_in=7'b0010000 (level 5) → ipl{2,1,0}_n=010 exactly 3 clk later; mask=0 → 111.
- irq_in levels 2 and 6 simultaneously, mask=7F → IPL 001 (level 6); drop level 6 → 101 (level 2).
- Edge mode level 4, pulse irq_in 1 clk, IACK cycle with A3..A1=4, IACK_WAIT=2 → dtack_n low and vec_data=8'h44 3 clk after synced AS; pending[3] cleared; IPL 111.
- IACK level 3 with nothing pending → vec_data=8'h18, dtack_n low, registers unchanged.
- W1C on pending coincident with a new edge on the same level → pending stays 1.
- as_n released during WAIT and rst_n pulsed during ACK → dtack_n=1, vec_oe=0 immediately, FSM IDLE.
